// File: rtl/fpu_pkg.sv
// Shared FPU types and constants.
// Used by the fadd issue controller and its result FIFO.
package fpu_pkg;

  localparam int FADD_LAT  = 2;
  localparam int RES_TAG_W = 5;

  typedef enum logic {
    FADD = 1'b0,
    FSUB = 1'b1
  } fadd_op_t;

  typedef struct packed {
    fadd_op_t              op;
    logic [31:0]           rs1;
    logic [31:0]           rs2;
    logic [RES_TAG_W-1:0]  tag;
  } fadd_req_t;

  typedef struct packed {
    logic [31:0]           y;
    logic                  ovf;
    logic [RES_TAG_W-1:0]  tag;
  } fadd_res_t;

  function automatic logic [31:0] neg_sign(
    input logic [31:0] v
  );
    return {~v[31], v[30:0]};
  endfunction

endpackage

// File: rtl/fadd_issue_ctrl_if.sv
// Dispatch, fadd and writeback signals of the fadd issue controller.
// slave is the controller side, master the environment side.
interface fadd_issue_ctrl_if #(
  parameter int TAG_W = fpu_pkg::RES_TAG_W
);
  logic             req_valid;
  logic             req_ready;
  logic             req_sub;
  logic [31:0]      req_rs1;
  logic [31:0]      req_rs2;
  logic [TAG_W-1:0] req_tag;
  logic [31:0]      fa_x1;
  logic [31:0]      fa_x2;
  logic             fa_enable_in;
  logic [31:0]      fa_y;
  logic             fa_ovf;
  logic             fa_enable_out;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_y;
  logic             res_ovf;
  logic [TAG_W-1:0] res_tag;

  modport slave (
    input  req_valid, req_sub, req_rs1,
    input  req_rs2, req_tag,
    input  fa_y, fa_ovf, fa_enable_out,
    input  res_ready,
    output req_ready,
    output fa_x1, fa_x2, fa_enable_in,
    output res_valid, res_y, res_ovf, res_tag
  );

  modport master (
    output req_valid, req_sub, req_rs1,
    output req_rs2, req_tag,
    output fa_y, fa_ovf, fa_enable_out,
    output res_ready,
    input  req_ready,
    input  fa_x1, fa_x2, fa_enable_in,
    input  res_valid, res_y, res_ovf, res_tag
  );
endinterface

// File: rtl/fadd_result_fifo.sv
// Show-ahead synchronous result FIFO with synchronous clear.
// Head is read from registers; empty head reads as zero.
module fadd_result_fifo
  import fpu_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fadd_res_t
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic push,
  input  logic pop,
  input  T     wdata,
  output logic valid,
  output T     rdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  T              mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign valid   = (cnt != '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_pop  = pop & valid;
  assign do_push = push & (~full | do_pop);
  assign rdata   = valid ? mem[rptr] : T'('0);

  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push)
        wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
      if (do_pop)
        rptr <= (rptr == LAST) ? '0 : rptr + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wptr] <= wdata;
  end

endmodule

// File: rtl/fadd_issue_ctrl.sv
// Issue/credit/tag tracking around the fixed-latency fadd pipe.
// Results are gathered into a credit-protected result FIFO.
module fadd_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int TAG_W = RES_TAG_W,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic flush,
  fadd_issue_ctrl_if.slave bus
);

  localparam int NS = FADD_LAT + 1;
  localparam int CW = $clog2(DEPTH + 1);

  fadd_req_t        req;
  fadd_res_t        cap;
  fadd_res_t        head;
  logic [CW-1:0]    outs_q;
  logic [CW-1:0]    outs_d;
  logic [NS-1:0]    v_q;
  logic [NS-1:0]    k_q;
  logic [TAG_W-1:0] tag_q [NS];
  logic [31:0]      x1_q;
  logic [31:0]      x2_q;
  logic             en_q;
  logic             accept;
  logic             push;
  logic             drop;
  logic             pop;
  logic             head_valid;

  assign req = '{
    op:  fadd_op_t'(bus.req_sub),
    rs1: bus.req_rs1,
    rs2: bus.req_rs2,
    tag: bus.req_tag
  };

  assign bus.req_ready = rstn & ~flush
                       & (outs_q < CW'(DEPTH));
  assign accept = bus.req_valid & bus.req_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      x1_q <= '0;
      x2_q <= '0;
      en_q <= 1'b0;
    end else begin
      en_q <= accept;
      if (accept) begin
        x1_q <= req.rs1;
        x2_q <= (req.op == FSUB) ? neg_sign(req.rs2)
                                 : req.rs2;
      end
    end
  end

  // Kill marks every in-flight stage; invalid stages ignore it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      v_q <= '0;
      k_q <= '0;
    end else begin
      v_q <= {v_q[NS-2:0], accept};
      k_q <= {k_q[NS-2:0], 1'b0} | {NS{flush}};
    end
  end

  always_ff @(posedge clk) begin
    tag_q[0] <= req.tag;
    for (int i = 1; i < NS; i++)
      tag_q[i] <= tag_q[i-1];
  end

  assign push = v_q[NS-1] & ~k_q[NS-1]
              & bus.fa_enable_out & ~flush;
  assign drop = v_q[NS-1] & ~push;
  assign pop  = head_valid & bus.res_ready & ~flush;

  // On flush only entries still shifting through the pipe keep credit.
  always_comb begin
    outs_d = outs_q;
    if (flush)
      outs_d = CW'($countones(v_q[NS-2:0]));
    else
      outs_d = outs_q + CW'(accept)
             - CW'(pop) - CW'(drop);
  end

  always_ff @(posedge clk) begin
    if (!rstn)
      outs_q <= '0;
    else
      outs_q <= outs_d;
  end

  assign cap = '{
    y:   bus.fa_y,
    ovf: bus.fa_ovf,
    tag: tag_q[NS-1]
  };

  fadd_result_fifo #(
    .DEPTH (DEPTH),
    .T     (fadd_res_t)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (flush),
    .push  (push),
    .pop   (pop),
    .wdata (cap),
    .valid (head_valid),
    .rdata (head)
  );

  assign bus.fa_x1        = x1_q;
  assign bus.fa_x2        = x2_q;
  assign bus.fa_enable_in = en_q;
  assign bus.res_valid    = head_valid;
  assign bus.res_y        = head.y;
  assign bus.res_ovf      = head.ovf;
  assign bus.res_tag      = head.tag;

endmodule

// File: tb/tb_fadd_issue_ctrl.sv
// Directed bench for fadd_issue_ctrl with a 2-cycle fadd stand-in.
// Expected values are hand-computed per scenario.
module tb_fadd_issue_ctrl;
  import fpu_pkg::*;

  logic clk   = 1'b0;
  logic rstn  = 1'b0;
  logic flush = 1'b0;
  int   errors = 0;
  int   checks = 0;

  fadd_issue_ctrl_if #(.TAG_W(5)) bus ();

  fadd_issue_ctrl #(
    .TAG_W (5),
    .DEPTH (4)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // fadd stand-in: table for directed vectors, integer sum otherwise
  function automatic logic [32:0] fadd_ref(
    input logic [31:0] a,
    input logic [31:0] b
  );
    if (a == 32'h3F800000 && b == 32'h40000000)
      return {32'h40400000, 1'b0};
    if (a == 32'h3F800000 && b == 32'hBF800000)
      return {32'h00000000, 1'b0};
    if (a == 32'h7F7FFFFF && b == 32'h7F7FFFFF)
      return {32'h7F800000, 1'b1};
    return {32'(a + b), 1'b0};
  endfunction

  logic        e1, e2;
  logic [32:0] d1, d2;

  always @(posedge clk) begin
    if (!rstn) begin
      e1 <= 1'b0;
      e2 <= 1'b0;
      d1 <= '0;
      d2 <= '0;
    end else begin
      e1 <= bus.fa_enable_in;
      e2 <= e1;
      d1 <= fadd_ref(bus.fa_x1, bus.fa_x2);
      d2 <= d1;
    end
  end

  assign bus.fa_enable_out = e2;
  assign bus.fa_y          = d2[32:1];
  assign bus.fa_ovf        = d2[0];

  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      checks++;
      if (bus.fa_enable_out !== dut.v_q[FADD_LAT]) begin
        errors++;
        $display("FAIL protocol_en_out got=%b exp=%b",
                 bus.fa_enable_out, dut.v_q[FADD_LAT]);
      end
      checks++;
      if (dut.u_fifo.push && dut.u_fifo.full
          && !dut.u_fifo.do_pop) begin
        errors++;
        $display("FAIL push_full got=1 exp=0");
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic issue_one(
    input  logic        sub,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  t,
    output int          lat,
    output logic [31:0] y,
    output logic        ovf,
    output logic [4:0]  tg,
    output logic [31:0] x2,
    output logic        en
  );
    lat = -1;
    y   = '0;
    ovf = 1'b0;
    tg  = '0;
    x2  = '0;
    en  = 1'b0;
    @(negedge clk);
    bus.res_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_sub   = sub;
    bus.req_rs1   = a;
    bus.req_rs2   = b;
    bus.req_tag   = t;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) begin
        x2 = bus.fa_x2;
        en = bus.fa_enable_in;
        bus.req_valid = 1'b0;
      end
      if (bus.res_valid && lat < 0) begin
        lat = k;
        y   = bus.res_y;
        ovf = bus.res_ovf;
        tg  = bus.res_tag;
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_ready got=%b exp=0",
               bus.req_ready);
    end
    checks++;
    if (bus.fa_enable_in !== 1'b0 ||
        bus.fa_x1 !== '0 || bus.fa_x2 !== '0) begin
      errors++;
      $display("FAIL rst_issue got=%b/%h/%h exp=0/0/0",
               bus.fa_enable_in, bus.fa_x1, bus.fa_x2);
    end
    checks++;
    if (bus.res_valid !== 1'b0 || bus.res_y !== '0 ||
        bus.res_ovf !== 1'b0 || bus.res_tag !== '0) begin
      errors++;
      $display("FAIL rst_res got=%b/%h/%b/%h exp=0/0/0/0",
               bus.res_valid, bus.res_y,
               bus.res_ovf, bus.res_tag);
    end
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_release_ready got=%b exp=1",
               bus.req_ready);
    end
  endtask

  task automatic test_fadd();
    int lat;
    logic [31:0] y, x2;
    logic ovf, en;
    logic [4:0] tg;
    issue_one(1'b0, 32'h3F800000, 32'h40000000, 5'd3,
              lat, y, ovf, tg, x2, en);
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL fadd_latency got=%0d exp=4", lat);
    end
    checks++;
    if (en !== 1'b1 || x2 !== 32'h40000000) begin
      errors++;
      $display("FAIL fadd_issue got=%b/%h exp=1/40000000",
               en, x2);
    end
    checks++;
    if (y !== 32'h40400000 || ovf !== 1'b0 ||
        tg !== 5'd3) begin
      errors++;
      $display("FAIL fadd_result got=%h/%b/%0d exp=40400000/0/3",
               y, ovf, tg);
    end
  endtask

  task automatic test_fsub();
    int lat;
    logic [31:0] y, x2;
    logic ovf, en;
    logic [4:0] tg;
    issue_one(1'b1, 32'h3F800000, 32'h3F800000, 5'd7,
              lat, y, ovf, tg, x2, en);
    checks++;
    if (x2 !== 32'hBF800000) begin
      errors++;
      $display("FAIL fsub_x2 got=%h exp=BF800000", x2);
    end
    checks++;
    if (lat != 4 || y !== 32'h0 || tg !== 5'd7) begin
      errors++;
      $display("FAIL fsub_result got=%0d/%h/%0d exp=4/0/7",
               lat, y, tg);
    end
  endtask

  task automatic test_ovf();
    int lat;
    logic [31:0] y, x2;
    logic ovf, en;
    logic [4:0] tg;
    issue_one(1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 5'd9,
              lat, y, ovf, tg, x2, en);
    checks++;
    if (lat != 4 || y !== 32'h7F800000 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_result got=%0d/%h/%b exp=4/7F800000/1",
               lat, y, ovf);
    end
  endtask

  task automatic test_credit();
    int acc = 0;
    @(negedge clk);
    bus.res_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_sub   = 1'b0;
      bus.req_rs1   = 32'(i);
      bus.req_rs2   = 32'h0;
      bus.req_tag   = 5'(i);
      #1;
      if (bus.req_ready) acc++;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (acc != 4) begin
      errors++;
      $display("FAIL credit_accepts got=%0d exp=4", acc);
    end
    checks++;
    if (bus.req_ready !== 1'b0 || bus.res_valid !== 1'b1) begin
      errors++;
      $display("FAIL credit_full got=%b/%b exp=0/1",
               bus.req_ready, bus.res_valid);
    end
    @(negedge clk);
    bus.res_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_pop got=%b exp=0",
               bus.req_ready);
    end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (bus.res_valid !== 1'b1 || bus.res_tag !== 5'(i)) begin
        errors++;
        $display("FAIL credit_order got=%b/%0d exp=1/%0d",
                 bus.res_valid, bus.res_tag, i);
      end
      if (i == 1) begin
        checks++;
        if (bus.req_ready !== 1'b1) begin
          errors++;
          $display("FAIL ready_after_pop got=%b exp=1",
                   bus.req_ready);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (bus.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL credit_drained got=%b exp=0",
               bus.res_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] eq_y [$];
    logic [4:0]  eq_t [$];
    int sent = 0;
    int rcv  = 0;
    int cyc  = 0;
    logic seen;
    while (rcv < 20 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      bus.res_ready = (cyc % 2) == 1;
      if (sent < 20) begin
        bus.req_valid = 1'b1;
        bus.req_sub   = 1'b0;
        bus.req_rs1   = 32'(32'h1000 + sent);
        bus.req_rs2   = 32'(sent);
        bus.req_tag   = 5'(sent);
      end else begin
        bus.req_valid = 1'b0;
      end
      #1;
      if (bus.res_valid && bus.res_ready) begin
        checks++;
        if (eq_y.size() == 0) begin
          errors++;
          $display("FAIL stream_extra got=%0d exp=none",
                   bus.res_tag);
        end else begin
          if (bus.res_y !== eq_y[0] ||
              bus.res_tag !== eq_t[0]) begin
            errors++;
            $display("FAIL stream_data got=%h/%0d exp=%h/%0d",
                     bus.res_y, bus.res_tag, eq_y[0], eq_t[0]);
          end
          void'(eq_y.pop_front());
          void'(eq_t.pop_front());
        end
        rcv++;
      end
      if (bus.req_valid && bus.req_ready) begin
        eq_y.push_back(32'(32'h1000 + 2 * sent));
        eq_t.push_back(5'(sent));
        sent++;
      end
    end
    checks++;
    if (rcv != 20 || sent != 20) begin
      errors++;
      $display("FAIL stream_count got=%0d/%0d exp=20/20",
               sent, rcv);
    end
    bus.req_valid = 1'b0;
    bus.res_ready = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.res_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL stream_dup got=%b exp=0", seen);
    end
  endtask

  task automatic test_flush();
    int lat;
    logic [31:0] y, x2;
    logic ovf, en, seen;
    logic [4:0] tg;
    @(negedge clk);
    bus.res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_sub   = 1'b0;
      bus.req_rs1   = 32'(i);
      bus.req_rs2   = 32'h0;
      bus.req_tag   = 5'(10 + i);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_tag !== 5'd10) begin
      errors++;
      $display("FAIL flush_queued got=%b/%0d exp=1/10",
               bus.res_valid, bus.res_tag);
    end
    flush = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready got=%b exp=0",
               bus.req_ready);
    end
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (bus.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_clear got=%b exp=0",
               bus.res_valid);
    end
    bus.res_ready = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.res_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL flush_squash got=%b exp=0", seen);
    end
    checks++;
    if (dut.outs_q !== '0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_credit got=%0d/%b exp=0/1",
               dut.outs_q, bus.req_ready);
    end
    issue_one(1'b0, 32'h3F800000, 32'h40000000, 5'd13,
              lat, y, ovf, tg, x2, en);
    checks++;
    if (lat != 4 || y !== 32'h40400000 || tg !== 5'd13) begin
      errors++;
      $display("FAIL flush_after got=%0d/%h/%0d exp=4/40400000/13",
               lat, y, tg);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    @(negedge clk);
    bus.res_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_sub   = 1'b0;
      bus.req_rs1   = 32'h3F800000;
      bus.req_rs2   = 32'h40000000;
      bus.req_tag   = 5'(20 + i);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b0 || bus.fa_enable_in !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ctrl got=%b/%b exp=0/0",
               bus.req_ready, bus.fa_enable_in);
    end
    checks++;
    if (bus.fa_x1 !== '0 || bus.fa_x2 !== '0) begin
      errors++;
      $display("FAIL midrst_x got=%h/%h exp=0/0",
               bus.fa_x1, bus.fa_x2);
    end
    checks++;
    if (bus.res_valid !== 1'b0 || bus.res_y !== '0 ||
        bus.res_ovf !== 1'b0 || bus.res_tag !== '0) begin
      errors++;
      $display("FAIL midrst_res got=%b/%h/%b/%h exp=0/0/0/0",
               bus.res_valid, bus.res_y,
               bus.res_ovf, bus.res_tag);
    end
    rstn = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.res_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_stale got=%b/%b exp=0/1",
               seen, bus.req_ready);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_sub   = 1'b0;
    bus.req_rs1   = '0;
    bus.req_rs2   = '0;
    bus.req_tag   = '0;
    bus.res_ready = 1'b0;
    test_reset();
    test_fadd();
    test_fsub();
    test_ovf();
    test_credit();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/fadd_issue_ctrl.md
Name: fadd_issue_ctrl

Overview:
- Sits between the core's FP dispatch and the `fadd` pipeline, on both its input and output sides.
- Accepts FADD/FSUB requests through a valid/ready handshake and registers the operands into `fadd`. For FSUB it inverts the sign bit of the second operand.
- Carries each request's destination tag alongside the fixed-latency `fadd` pipeline, which has no stall and no tag.
- Collects `y`/`ovf` into a small result FIFO drained by writeback. Credit-based issue guarantees the FIFO never overflows. `flush` squashes everything in flight.

Parameters:
- TAG_W, 5: destination-register tag width.
- DEPTH, 4: result FIFO depth; also the maximum number of outstanding operations.
- FADD_LAT, 2: cycles from `fa_enable_in` to `fa_enable_out` of `fadd`.

Ports:
- clk  in  1  clock; single clock domain.
- rstn  in  1  reset; synchronous, active-low.
- flush  in  1  squash all outstanding and queued operations.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when `req_valid` && `req_ready`.
- req_sub  in  1  0 = FADD, 1 = FSUB.
- req_rs1  in  32  operand a (IEEE-754 single).
- req_rs2  in  32  operand b.
- req_tag  in  TAG_W  destination tag.
- fa_x1  out  32  to `fadd` `x1`.
- fa_x2  out  32  to `fadd` `x2`.
- fa_enable_in  out  1  to `fadd` `enable_in`.
- fa_y  in  32  from `fadd` `y`.
- fa_ovf  in  1  from `fadd` `ovf`.
- fa_enable_out  in  1  from `fadd` `enable_out`.
- res_valid  out  1  FIFO head valid.
- res_ready  in  1  writeback pops the head when `res_valid` && `res_ready`.
- res_y  out  32  result value.
- res_ovf  out  1  overflow flag.
- res_tag  out  TAG_W  result tag.

Behaviour:
- Reset (`rstn`=0 at a clk edge):
  - Outputs: `req_ready`=0 during reset, `fa_enable_in`=0, `fa_x1`=`fa_x2`=0, `res_valid`=0, `res_y`=0, `res_ovf`=0, `res_tag`=0.
  - State: tag pipe emptied; FIFO pointers and count = 0; `outstanding` = 0.
- Issue stage (registered):
  - On accept: `fa_x1`<=`req_rs1`; `fa_x2`<=`req_sub` ? {~`req_rs2`[31], `req_rs2`[30:0]} : `req_rs2`; `fa_enable_in`<=1.
  - Otherwise `fa_enable_in`<=0 and `fa_x*` hold.
- Credit:
  - `outstanding` = issue stage + tag pipe + FIFO entries, range 0..DEPTH.
  - `req_ready` = (`outstanding` < DEPTH) && !`flush` && `rstn`; it depends only on registers and `flush`.
  - Per cycle, `outstanding` += accept and −= pop; both may occur in the same cycle, giving no change.
  - Dropped (killed) results also decrement `outstanding`.
- Tag pipe:
  - FADD_LAT+1 stages of {valid, kill, tag}, advancing every cycle.
  - Stage 0 is loaded on accept.
  - The last stage aligns with `fa_enable_out`.
- Capture: when `fa_enable_out`=1, push {`fa_y`, `fa_ovf`, tag} into the FIFO if the last stage is valid and not killed; otherwise drop.
  - If `fa_enable_out` disagrees with the last-stage valid, this is a protocol error. The bench asserts on it; the RTL ignores the result.
- Latency: accept at edge of cycle T → `fa_enable_in` high in T+1 → `fa_enable_out` in T+1+FADD_LAT → `res_valid` in T+2+FADD_LAT (4 cycles at default).
  - Back-to-back throughput is 1 per cycle while credits remain.
- FIFO:
  - Show-ahead: the head is driven from registers.
  - Push and pop in the same cycle are legal at any count.
  - Pop when empty: no effect.
  - Push when full: impossible by credit; the bench asserts it never happens.
- Flush:
  - Accept is blocked in the flush cycle.
  - Sets `kill` on every valid tag-pipe stage, including stage 0 and the issue stage.
  - FIFO is cleared next cycle (`res_valid`=0 at T+1); a pop in the flush cycle is ignored.
  - `outstanding` is set to the count of killed in-flight entries, which then drain to 0.
  - A `fa_enable_out` in the flush cycle is dropped.
- Special values (NaN, inf, ovf): passed through unchanged. FSUB flips the NaN sign with no canonicalisation.
- Reset mid-operation: all state is discarded. `fadd` is reset from the same `rstn` and its internal enables are not relied upon; the tag pipe gates capture.

Decomposition:
- Package `fpu_pkg`:
  - Constant FADD_LAT=2.
  - `fadd_op_t` enum {FADD, FSUB}.
  - `fadd_req_t` struct {op, rs1, rs2, tag}.
  - `fadd_res_t` struct {y, ovf, tag}.
- Sub-module `fadd_result_fifo`: parameterised synchronous FIFO of `fadd_res_t`, with DEPTH, show-ahead, and a synchronous clear. It is reusable by the other FPU units.

Test Plan:
- FADD 0x3F800000 + 0x40000000, tag 3, `res_ready`=1 → `res_valid` 4 cycles after accept; `res_y`=0x40400000, `res_ovf`=0, `res_tag`=3.
- FSUB 0x3F800000 − 0x3F800000 → `fa_x2`=0xBF800000; `res_y`=0x00000000. Separately, FADD 0x7F7FFFFF + 0x7F7FFFFF → `res_y`=0x7F800000, `res_ovf`=1.
- `res_ready`=0 with 6 back-to-back requests (tags 0–5) → exactly 4 accepted and `req_ready`=0 afterwards. Then raise `res_ready` → tags 0,1,2,3 returned in order; `req_ready` reasserts the cycle after the first pop.
- Streaming with `res_ready` toggling 1/0 each cycle over 20 requests → no loss or duplication, in order, and no push-when-full assertion.
- Issue 3 requests, `flush` 1 cycle after the third accept with 1 result already queued → `res_valid`=0 the next cycle, no squashed result ever appears, and `outstanding` returns to 0. A request issued after the drain returns normally.
- Reset asserted with 2 operations in flight → all outputs 0 after the edge; no stale result appears after `rstn` deasserts.
